// File: rtl/modulation_stream_writer.sv
// Modulation buffer writer: packs an 8-bit valid/ready byte stream into 16-bit
// BRAM words ({odd, even}) and publishes the committed cycle length on success.
module modulation_stream_writer #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [15:0]           LEN_M,
    input  logic [7:0]            S_DATA,
    input  logic                  S_VALID,
    output logic                  S_READY,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [DATA_WIDTH-1:0] DIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [15:0]           CYCLE_M
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        FINISH = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            lo_q, lo_d;
    logic                  ready_q, ready_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           cyc_q, cyc_d;
    logic                  accept;

    // A byte is taken whenever the registered ready is up and the source offers one.
    assign accept = ready_q && S_VALID;

    // Next-state, packing and write-issue logic; ABORT overrides everything else.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        done_d  = 1'b0;
        cyc_d   = cyc_q;
        if (ABORT) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        state_d = RECV;
                        len_d   = LEN_M;
                        cnt_d   = '0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        addr_d = cnt_q[ADDR_WIDTH:1];
                        if (cnt_q[0]) begin
                            we_d  = 1'b1;
                            din_d = {S_DATA, lo_q};
                        end else begin
                            lo_d = S_DATA;
                        end
                        if (cnt_q == len_q) begin
                            // A trailing even byte is flushed with a zero upper half.
                            if (!cnt_q[0]) begin
                                we_d  = 1'b1;
                                din_d = {8'h00, S_DATA};
                            end
                            state_d = FINISH;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cyc_d   = len_q;
                end
                default: state_d = IDLE;
            endcase
        end
        ready_d = (state_d == RECV);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs; synchronous reset clears everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
        end
    end

    assign S_READY = ready_q;
    assign WE      = we_q;
    assign ADDR    = addr_q;
    assign DIN     = din_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign CYCLE_M = cyc_q;

endmodule

// File: tb/tb_modulation_stream_writer.sv
// Randomized bench for modulation_stream_writer: byte-stream model predicts the
// packed word list and commit timing, compared against a log of observed writes.
module tb_modulation_stream_writer;

    logic        CLK = 1'b0;
    logic        RST, START, ABORT, S_VALID;
    logic [15:0] LEN_M;
    logic [7:0]  S_DATA;
    logic        S_READY, WE, BUSY, DONE;
    logic [14:0] ADDR;
    logic [15:0] DIN;
    logic [15:0] CYCLE_M;

    int n_tests = 0;
    int n_fail  = 0;

    logic [30:0] wlog[$];      // observed writes {addr, din}
    logic [7:0]  bytes_q[$];   // bytes sent in current transfer
    logic [15:0] cyc_model = 16'd0;

    modulation_stream_writer dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .LEN_M(LEN_M),
        .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY), .WE(WE),
        .ADDR(ADDR), .DIN(DIN), .BUSY(BUSY), .DONE(DONE), .CYCLE_M(CYCLE_M)
    );

    always #5 CLK = ~CLK;

    // Record every write at mid-cycle, away from the active edge.
    always @(negedge CLK) if (WE) wlog.push_back({ADDR, DIN});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic begin_xfer(input logic [15:0] len);
        wlog.delete();
        bytes_q.delete();
        LEN_M = len;
        START = 1'b1;
        tick();
        START = 1'b0;
        LEN_M = $urandom;
    endtask

    // Offer one byte after an optional random gap; S_READY stays high throughout RECV.
    task automatic send_byte(input logic [7:0] b, input int gap_mod);
        if (gap_mod > 0) begin
            while ($urandom_range(gap_mod - 1) == 0) begin
                S_VALID = 1'b0;
                S_DATA  = $urandom;
                tick();
            end
        end
        S_VALID = 1'b1;
        S_DATA  = b;
        bytes_q.push_back(b);
        tick();
        S_VALID = 1'b0;
    endtask

    // Compare the write log with words packed from the first n_words*2 sent bytes.
    task automatic check_words(input string tag, input int n_words);
        logic [7:0]  hi;
        logic [30:0] exp;
        chk({tag, "_nwr"}, wlog.size(), n_words);
        for (int k = 0; k < n_words && k < wlog.size(); k++) begin
            hi  = (2 * k + 1 < bytes_q.size()) ? bytes_q[2 * k + 1] : 8'h00;
            exp = {k[14:0], hi, bytes_q[2 * k]};
            chk({tag, "_wr"}, {1'b0, wlog[k]}, {1'b0, exp});
        end
    endtask

    // Full transfer with commit timing checks; src: 0 random, 1 = 11,22,33.. pattern.
    task automatic full_xfer(input string tag, input int len_m, input int gap_mod, input int src);
        int n;
        n = len_m + 1;
        begin_xfer(len_m[15:0]);
        chk({tag, "_rdy"}, S_READY, 1'b1);
        chk({tag, "_busy"}, BUSY, 1'b1);
        for (int i = 0; i < n; i++)
            send_byte(src == 1 ? 8'((i + 1) * 8'h11) : 8'($urandom), gap_mod);
        // T'+1: final write, still busy, old length visible
        chk({tag, "_we_last"}, WE, 1'b1);
        chk({tag, "_busy_fin"}, BUSY, 1'b1);
        chk({tag, "_rdy_fin"}, S_READY, 1'b0);
        chk({tag, "_done_early"}, DONE, 1'b0);
        chk({tag, "_cyc_old"}, CYCLE_M, cyc_model);
        tick();
        cyc_model = len_m[15:0];
        chk({tag, "_done"}, DONE, 1'b1);
        chk({tag, "_busy_end"}, BUSY, 1'b0);
        chk({tag, "_cyc_new"}, CYCLE_M, cyc_model);
        tick();
        chk({tag, "_done_pulse"}, DONE, 1'b0);
        check_words(tag, (n + 1) / 2);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; ABORT = 1'b0; S_VALID = 1'b0;
        LEN_M = '0; S_DATA = '0;
        tick(); tick();
        chk("rst_rdy", S_READY, 1'b0);
        chk("rst_we", WE, 1'b0);
        chk("rst_addr", ADDR, 15'd0);
        chk("rst_din", DIN, 16'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_cyc", CYCLE_M, 16'd0);
        RST = 1'b0;
        tick();

        // START and ABORT together in IDLE: stay idle
        START = 1'b1; ABORT = 1'b1; LEN_M = 16'd5;
        tick();
        START = 1'b0; ABORT = 1'b0;
        chk("sa_busy", BUSY, 1'b0);
        chk("sa_rdy", S_READY, 1'b0);

        full_xfer("t2", 4, 0, 1);   // 11..55 -> third word 0055
        full_xfer("t3", 0, 0, 0);   // single even byte
        full_xfer("t1", 3, 0, 1);   // 2211, 4433, CYCLE_M=3

        // ABORT after 3 bytes, with a 4th byte offered on the abort cycle
        begin_xfer(16'd9);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
        ABORT = 1'b1; S_VALID = 1'b1; S_DATA = 8'hEE;
        tick();
        ABORT = 1'b0; S_VALID = 1'b0;
        chk("ab_busy", BUSY, 1'b0);
        chk("ab_rdy", S_READY, 1'b0);
        chk("ab_we", WE, 1'b0);
        tick();
        chk("ab_done", DONE, 1'b0);
        chk("ab_cyc", CYCLE_M, 16'd3);
        check_words("ab", 1);

        // START mid-RECV must not reload the length
        begin_xfer(16'd3);
        send_byte(8'($urandom), 0);
        START = 1'b1; LEN_M = 16'd0;
        tick();
        START = 1'b0;
        chk("ms_busy", BUSY, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
        chk("ms_we", WE, 1'b1);
        tick();
        chk("ms_done", DONE, 1'b1);
        chk("ms_cyc", CYCLE_M, 16'd3);
        tick();
        check_words("ms", 2);

        // random short transfers
        for (int t = 0; t < 12; t++)
            full_xfer("rnd", $urandom_range(0, 20), 3, 0);

        // RST mid-RECV: everything back to zero, no DONE
        begin_xfer(16'd5);
        for (int i = 0; i < 2; i++) send_byte(8'($urandom), 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        cyc_model = 16'd0;
        chk("mr_rdy", S_READY, 1'b0);
        chk("mr_we", WE, 1'b0);
        chk("mr_addr", ADDR, 15'd0);
        chk("mr_din", DIN, 16'd0);
        chk("mr_busy", BUSY, 1'b0);
        chk("mr_cyc", CYCLE_M, 16'd0);
        tick();
        chk("mr_done", DONE, 1'b0);

        // full 64 KiB transfer with sparse stalls
        full_xfer("big", 16'hFFFF, 16, 0);
        if (wlog.size() > 0) chk("big_last_addr", wlog[wlog.size() - 1][30:16], 15'h7FFF);
        else chk("big_last_addr", 32'hFFFF_FFFF, 15'h7FFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
